// File: rtl/cordic_cpu_pkg.sv
// Shared types and instruction-word layout for the CORDIC processor control FSM.
package cordic_cpu_pkg;

  localparam int IR_W   = 14;
  localparam int OPC_HI = 13;
  localparam int OPC_LO = 10;
  localparam int RX_HI  = 9;
  localparam int RX_LO  = 5;
  localparam int RY_HI  = 4;
  localparam int RY_LO  = 0;

  typedef enum logic [3:0] {
    OP_MV  = 4'd0,
    OP_MVI = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_SIN = 4'd4,
    OP_COS = 4'd5
  } opcode_t;

  typedef enum logic [2:0] {
    T0, T1, T2, T3, WAIT, WB, ABORT
  } state_t;

endpackage

// File: rtl/cordic_cpu_control_onehot_dec5.sv
// 5-bit index to one-hot decoder with enable; all outputs 0 when disabled.
module onehot_dec5 #(
  parameter int N = 32
) (
  input  logic [4:0]   idx,
  input  logic         en,
  output logic [N-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign onehot[gi] = en && (idx == 5'(gi));
    end
  endgenerate

endmodule

// File: rtl/cordic_cpu_control.sv
// Control FSM for the CORDIC processor: fetches an instruction, then sequences
// bus sources, register loads, the ALU and the CORDIC start/done handshake.
module cordic_cpu_control
  import cordic_cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NREG           = 32
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Run,
  input  logic [31:0]     DIN,
  input  logic            cordic_done,
  output logic [NREG-1:0] Rout,
  output logic            Gout,
  output logic            DINout,
  output logic            Sinout,
  output logic            Cosout,
  output logic [NREG-1:0] Rin,
  output logic            Ain,
  output logic            Gin,
  output logic            AddSub,
  output logic            IRin,
  output logic            cordic_start,
  output logic            Done,
  output logic            Err
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [IR_W-1:0] ir;
  logic [CW-1:0]   cnt;

  logic [3:0] opcode;
  logic [4:0] rx;
  logic [4:0] ry;

  logic       rout_en;
  logic [4:0] rout_idx;
  logic       rin_en;
  logic [4:0] rin_idx;

  // Upper instruction bits carry no meaning for the controller.
  logic din_unused;
  assign din_unused = ^DIN[31:IR_W];

  assign opcode = ir[OPC_HI:OPC_LO];
  assign rx     = ir[RX_HI:RX_LO];
  assign ry     = ir[RY_HI:RY_LO];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        T0: begin
          if (Run) begin
            ir    <= DIN[IR_W-1:0];
            state <= T1;
          end
        end
        T1: begin
          case (opcode)
            OP_ADD, OP_SUB: state <= T2;
            OP_SIN, OP_COS: begin
              cnt   <= '0;
              state <= WAIT;
            end
            default: state <= T0;
          endcase
        end
        T2: state <= T3;
        // A result arriving on the last allowed cycle still wins over the timeout.
        WAIT: begin
          if (cordic_done)          state <= WB;
          else if (cnt == CNT_LAST) state <= ABORT;
          else                      cnt   <= cnt + 1'b1;
        end
        default: state <= T0;
      endcase
    end
  end

  always_comb begin
    rout_en      = 1'b0;
    rout_idx     = '0;
    rin_en       = 1'b0;
    rin_idx      = '0;
    Gout         = 1'b0;
    DINout       = 1'b0;
    Sinout       = 1'b0;
    Cosout       = 1'b0;
    Ain          = 1'b0;
    Gin          = 1'b0;
    AddSub       = 1'b0;
    IRin         = 1'b0;
    cordic_start = 1'b0;
    Done         = 1'b0;
    Err          = 1'b0;
    case (state)
      T0: IRin = Run && Resetn;
      T1: begin
        case (opcode)
          OP_MV: begin
            rout_en  = 1'b1;
            rout_idx = ry;
            rin_en   = 1'b1;
            rin_idx  = rx;
            Done     = 1'b1;
          end
          OP_MVI: begin
            DINout  = 1'b1;
            rin_en  = 1'b1;
            rin_idx = rx;
            Done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout_en  = 1'b1;
            rout_idx = rx;
            Ain      = 1'b1;
          end
          OP_SIN, OP_COS: begin
            rout_en      = 1'b1;
            rout_idx     = ry;
            cordic_start = 1'b1;
          end
          default: begin
            Done = 1'b1;
            Err  = 1'b1;
          end
        endcase
      end
      T2: begin
        rout_en  = 1'b1;
        rout_idx = ry;
        Gin      = 1'b1;
        AddSub   = (opcode == OP_SUB);
      end
      T3: begin
        Gout    = 1'b1;
        rin_en  = 1'b1;
        rin_idx = rx;
        Done    = 1'b1;
      end
      WB: begin
        Sinout  = (opcode == OP_SIN);
        Cosout  = (opcode == OP_COS);
        rin_en  = 1'b1;
        rin_idx = rx;
        Done    = 1'b1;
      end
      ABORT: begin
        Done = 1'b1;
        Err  = 1'b1;
      end
      default: ;
    endcase
  end

  onehot_dec5 #(.N(NREG)) u_rout_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (Rout)
  );

  onehot_dec5 #(.N(NREG)) u_rin_dec (
    .idx    (rin_idx),
    .en     (rin_en),
    .onehot (Rin)
  );

endmodule

// File: tb/tb_cordic_cpu_control.sv
// Self-checking bench: per-cycle expected outputs derived from instruction semantics and latency rules.
module tb_cordic_cpu_control;

  localparam int TO = 64;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Run;
  logic [31:0] DIN;
  logic        cordic_done;
  logic [31:0] Rout;
  logic        Gout, DINout, Sinout, Cosout;
  logic [31:0] Rin;
  logic        Ain, Gin, AddSub, IRin, cordic_start, Done, Err;

  typedef struct packed {
    logic [31:0] rout;
    logic        gout;
    logic        dinout;
    logic        sinout;
    logic        cosout;
    logic [31:0] rin;
    logic        ain;
    logic        gin;
    logic        addsub;
    logic        irin;
    logic        cstart;
    logic        done;
    logic        err;
  } outs_t;

  int vectors    = 0;
  int miscompares = 0;

  cordic_cpu_control #(.TIMEOUT_CYCLES(TO), .NREG(32)) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .Run          (Run),
    .DIN          (DIN),
    .cordic_done  (cordic_done),
    .Rout         (Rout),
    .Gout         (Gout),
    .DINout       (DINout),
    .Sinout       (Sinout),
    .Cosout       (Cosout),
    .Rin          (Rin),
    .Ain          (Ain),
    .Gin          (Gin),
    .AddSub       (AddSub),
    .IRin         (IRin),
    .cordic_start (cordic_start),
    .Done         (Done),
    .Err          (Err)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input outs_t e);
    outs_t a;
    a = '{Rout, Gout, DINout, Sinout, Cosout, Rin, Ain, Gin, AddSub, IRin,
          cordic_start, Done, Err};
    vectors++;
    assert (a === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, a, e);
    end
  endtask

  // Low phase of the next cycle: drive random don't-care inputs.
  task automatic next_cycle();
    @(negedge Clock);
    Run         = 1'($urandom());
    DIN         = $urandom();
    cordic_done = 1'($urandom());
  endtask

  task automatic idle();
    outs_t e;
    @(negedge Clock);
    Run         = 1'b0;
    DIN         = $urandom();
    cordic_done = 1'($urandom());
    #1;
    e = '0;
    chk("idle", e);
  endtask

  // k = WAIT cycle in which cordic_done rises; k > TO means never.
  task automatic exec(input logic [3:0] op, input logic [4:0] rx, input logic [4:0] ry,
                      input int k);
    outs_t       e;
    logic [31:0] r;
    bit          hit;
    r = $urandom();
    @(negedge Clock);
    Run         = 1'b1;
    DIN         = {r[31:14], op, rx, ry};
    cordic_done = 1'($urandom());
    #1;
    e = '0;
    e.irin = 1'b1;
    chk("fetch", e);

    next_cycle();
    #1;
    e = '0;
    case (op)
      4'd0: begin e.rout = 32'd1 << ry; e.rin = 32'd1 << rx; e.done = 1'b1; end
      4'd1: begin e.dinout = 1'b1; e.rin = 32'd1 << rx; e.done = 1'b1; end
      4'd2, 4'd3: begin e.rout = 32'd1 << rx; e.ain = 1'b1; end
      4'd4, 4'd5: begin e.rout = 32'd1 << ry; e.cstart = 1'b1; end
      default: begin e.done = 1'b1; e.err = 1'b1; end
    endcase
    chk("cycle2", e);

    if (op == 4'd2 || op == 4'd3) begin
      next_cycle();
      #1;
      e = '0;
      e.rout   = 32'd1 << ry;
      e.gin    = 1'b1;
      e.addsub = (op == 4'd3);
      chk("alu_op", e);
      next_cycle();
      #1;
      e = '0;
      e.gout = 1'b1;
      e.rin  = 32'd1 << rx;
      e.done = 1'b1;
      chk("alu_wb", e);
    end else if (op == 4'd4 || op == 4'd5) begin
      hit = 1'b0;
      for (int j = 1; j <= TO; j++) begin
        next_cycle();
        cordic_done = (j == k);
        #1;
        e = '0;
        chk("wait", e);
        if (j == k) begin
          hit = 1'b1;
          break;
        end
      end
      next_cycle();
      #1;
      e = '0;
      e.done = 1'b1;
      if (hit) begin
        e.sinout = (op == 4'd4);
        e.cosout = (op == 4'd5);
        e.rin    = 32'd1 << rx;
        chk("cordic_wb", e);
      end else begin
        e.err = 1'b1;
        chk("cordic_abort", e);
      end
    end
  endtask

  initial begin
    outs_t e;
    int    r, k;
    logic [3:0] op;

    Resetn      = 1'b0;
    Run         = 1'b1;
    DIN         = 32'h0000_0460;
    cordic_done = 1'b1;
    repeat (2) @(negedge Clock);
    #1;
    e = '0;
    chk("reset", e);
    @(negedge Clock);
    Resetn = 1'b1;
    Run    = 1'b0;
    #1;
    chk("post_reset", e);

    exec(4'd1, 5'd3, 5'd0, 0);           // mvi R3
    exec(4'd0, 5'd5, 5'd3, 0);           // mv R5,R3
    exec(4'd3, 5'd1, 5'd2, 0);           // sub R1,R2
    exec(4'd4, 5'd4, 5'd7, 10);          // sin R4,R7
    exec(4'd5, 5'd0, 5'd1, TO + 10);     // cos R0,R1 timeout
    exec(4'hF, 5'd2, 5'd9, 0);           // illegal
    exec(4'd4, 5'd6, 5'd6, 1);           // minimum wait
    exec(4'd5, 5'd8, 5'd2, TO);          // done on the last allowed cycle
    exec(4'd2, 5'd2, 5'd2, 0);           // add R2,R2
    idle();

    // Async reset during T2 of an add.
    exec(4'd1, 5'd9, 5'd0, 0);
    @(negedge Clock);
    Run = 1'b1;
    DIN = 32'h0000_0842;
    #1;
    e = '0;
    e.irin = 1'b1;
    chk("rst_fetch", e);
    next_cycle();
    #1;
    e = '0;
    e.rout = 32'd1 << 2;
    e.ain  = 1'b1;
    chk("rst_t1", e);
    @(negedge Clock);
    Resetn = 1'b0;
    Run    = 1'b1;
    #1;
    e = '0;
    chk("rst_async", e);
    @(negedge Clock);
    #1;
    chk("rst_held", e);
    @(negedge Clock);
    Resetn = 1'b1;
    Run    = 1'b0;
    #1;
    chk("rst_release", e);
    exec(4'd3, 5'd7, 5'd4, 0);

    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 8) ? 4'(r % 6) : 4'($urandom_range(6, 15));
      r  = $urandom_range(0, 9);
      k  = (r == 0) ? TO : (r == 1) ? TO + 5 : $urandom_range(1, 12);
      exec(op, 5'($urandom()), 5'($urandom()), k);
      if ($urandom_range(0, 2) == 0) idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cordic_cpu_control.md
Name: cordic_cpu_control

Overview:
Control FSM for the CORDIC processor datapath. Fetches an instruction word from DIN, then sequences the shared 32-bit BUS by driving exactly one one-hot bus-source select per cycle (R0..R31, G, DIN, Sin, Cos). It also drives register load enables, the ALU, and the CORDIC start/done handshake. It sits between the top-level Run/Done interface and the bus multiplexer/register file.

Parameters:
TIMEOUT_CYCLES, 64, max cycles to wait for cordic_done before aborting (must be >= 2)
NREG, 32, number of general registers (fixed at 32; 5-bit register fields)

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous active-low reset
Run  in  1  start an instruction; sampled only in T0
DIN  in  32  instruction word (T0) / immediate (mvi, T1)
cordic_done  in  1  CORDIC result valid on Sin/Cos; sampled only in WAIT
Rout  out  32  one-hot bus source select; bit i = RiOut
Gout  out  1  bus source select G
DINout  out  1  bus source select DIN
Sinout  out  1  bus source select Sin
Cosout  out  1  bus source select Cos
Rin  out  32  register load enables; bit i loads Ri from BUS
Ain  out  1  load ALU A register from BUS
Gin  out  1  load G with ALU result
AddSub  out  1  0 = add, 1 = subtract; valid with Gin
IRin  out  1  load instruction register from DIN
cordic_start  out  1  one-cycle pulse; CORDIC captures angle from BUS
Done  out  1  one-cycle pulse; instruction complete
Err  out  1  one-cycle pulse coincident with Done on timeout/illegal opcode

Behaviour:
- Clock and reset: single clock domain, Clock. Reset is asynchronous and active-low (Resetn). Resetn=0 forces state T0, IR=0, timeout counter=0, and all outputs 0, immediately and mid-instruction. Operation resumes on the first Clock edge after release.
- IR register: 14 bits, loaded from DIN[13:0] when IRin=1. Fields: opcode=IR[13:10], Rx=IR[9:5], Ry=IR[4:0]. DIN[31:14] is ignored.
- Opcodes: 0 mv, 1 mvi, 2 add, 3 sub, 4 sin, 5 cos. Values 6-15 are illegal.
- Outputs are combinational from the state register and IR. In every cycle at most one of {Rout bits, Gout, DINout, Sinout, Cosout} is 1. Outputs not listed for a state are 0.
- States and actions:
  - T0: IRin=Run. If Run, go to T1; otherwise stay in T0.
  - T1, mv: Rout[Ry], Rin[Rx], Done. Go to T0.
  - T1, mvi: DINout, Rin[Rx], Done. Go to T0.
  - T1, add/sub: Rout[Rx], Ain. Go to T2.
  - T1, sin/cos: Rout[Ry], cordic_start. Clear the counter. Go to WAIT.
  - T1, illegal: Done, Err, no Rin. Go to T0.
  - T2: Rout[Ry], Gin, AddSub=(opcode==sub). Go to T3.
  - T3: Gout, Rin[Rx], Done. Go to T0.
  - WAIT: all outputs 0.
    - If cordic_done, go to WB.
    - Else if counter==TIMEOUT_CYCLES-1, go to ABORT.
    - Else counter+1.
  - WB: Sinout (sin) or Cosout (cos), Rin[Rx], Done. Go to T0.
  - ABORT: Done, Err, no register write. Go to T0.
- Latency from the Run cycle:
  - mv/mvi: Done in the 2nd cycle.
  - add/sub: Done in the 4th cycle.
  - sin/cos: Done at 3+k cycles, where k = WAIT cycles until cordic_done (k>=1).
- Boundary conditions:
  - cordic_done high during T1 or any non-WAIT state is ignored.
  - cordic_done in the same cycle the counter reaches TIMEOUT_CYCLES-1: done wins, go to WB.
  - Run held high continuously issues back-to-back instructions, re-fetching in each T0. Run outside T0 is ignored.
  - Rx==Ry is legal (e.g. add R2,R2 doubles R2).
  - Counter width is $clog2(TIMEOUT_CYCLES). It never wraps; it is cleared in T1.

Decomposition:
- Package cordic_cpu_pkg: opcode enum (OP_MV..OP_COS), state enum (T0,T1,T2,T3,WAIT,WB,ABORT), IR field position constants, IR_W=14.
- One sub-module: onehot_dec5 (5-bit index plus enable to 32-bit one-hot). Instantiate twice, once for Rout and once for Rin.

Test Plan:
- mvi R3 (DIN=0x0000_0460), next cycle DIN=0x1234_5678 -> cycle 2: DINout=1, Rin=0x0000_0008, Done=1; all other selects 0.
- mv R5,R3 (DIN=0x0000_00A3) -> cycle 2: Rout=0x0000_0008, Rin=0x0000_0020, Done=1.
- sub R1,R2 (DIN=0x0000_0C22) -> T1: Rout bit1, Ain. T2: Rout bit2, Gin, AddSub=1. T3: Gout, Rin bit1, Done. Done in cycle 4.
- sin R4,R7 (DIN=0x0000_1087), cordic_done raised 10 cycles after cordic_start -> WB: Sinout=1, Rin=0x0000_0010, Done=1, Err=0. cordic_start high exactly one cycle.
- cos R0,R1 with cordic_done never asserted, TIMEOUT_CYCLES=64 -> ABORT after 64 WAIT cycles: Done=Err=1, Rin=0. Opcode 0xF -> Done=Err=1 in cycle 2.
- Resetn pulsed low during T2 of an add -> all outputs 0 immediately, no Rin pulse. The next Run fetches a fresh instruction normally.
